// File: rtl/ps2_scan_decoder.sv
// Generic single-clock FIFO. The head entry is presented combinationally.
// Latency: a pushed entry is visible on pop_vld/pop_dat the cycle after the write.
// Backpressure: push_rdy is low only when full with no pop in the same cycle.
module sync_fifo #(
    parameter int W     = 10,
    parameter int DEPTH = 8
) (
    input  logic         core_clk,
    input  logic         arst_n,
    input  logic         push_vld,
    input  logic [W-1:0] push_dat,
    output logic         push_rdy,
    output logic         pop_vld,
    input  logic         pop_rdy,
    output logic [W-1:0] pop_dat
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wptr, rptr;
    logic [W-1:0] mem [DEPTH];
    logic         full, empty, wr_en, rd_en;

    // The extra MSB tells full from empty when the index bits match.
    assign empty    = (wptr == rptr);
    assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign rd_en    = pop_rdy & ~empty;
    assign push_rdy = ~full | rd_en;
    assign wr_en    = push_vld & push_rdy;
    assign pop_vld  = ~empty;
    assign pop_dat  = mem[rptr[AW-1:0]];

    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            wptr <= '0;
            rptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (wr_en) begin
                mem[wptr[AW-1:0]] <= push_dat;
                wptr              <= wptr + (AW+1)'(1);
            end
            if (rd_en) rptr <= rptr + (AW+1)'(1);
        end
    end
endmodule

// PS/2 keyboard receiver: oversampled frame capture, E0/F0 folding, event FIFO.
// Latency: stop-bit strobe at N, event readable at N+2 when the FIFO was empty.
// Backpressure: RD_VALID/RD_READY; events arriving while full are dropped and flag OVERFLOW.
module ps2_scan_decoder #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int FIFO_DEPTH     = 8,
    parameter int MODE           = 0
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       PS2CLK,
    input  logic       PS2DATA,
    input  logic       RD_READY,
    output logic       RD_VALID,
    output logic [7:0] RD_CODE,
    output logic       RD_BREAK,
    output logic       RD_EXT,
    output logic [7:0] LAST_KEY,
    output logic       FRAME_ERR,
    output logic       OVERFLOW,
    input  logic       CLR_OVF
);
    localparam int FW  = $clog2(FILTER_LEN + 1);
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_ev_t;

    typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

    logic [1:0]     clk_sync, dat_sync;
    logic [FW-1:0]  flt_cnt;
    logic           clk_filt, clk_filt_d, strobe, dat_s;
    state_t         state, state_nxt;
    logic [3:0]     bit_cnt;
    logic [9:0]     shreg;
    logic [WDW-1:0] wd_cnt;
    logic           ext_pend, brk_pend;
    logic           err, is_e0, is_f0, ev_vld, push_vld, push_rdy, frame_ok;
    logic [7:0]     rx_byte;
    ps2_ev_t        ev_dat, head;

    assign dat_s   = dat_sync[1];
    assign strobe  = clk_filt_d & ~clk_filt;
    // shreg holds data[7:0], parity, stop once the stop bit has been shifted in.
    assign rx_byte = shreg[7:0];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            clk_sync   <= 2'b11;
            dat_sync   <= 2'b11;
            flt_cnt    <= '0;
            clk_filt   <= 1'b1;
            clk_filt_d <= 1'b1;
        end else begin
            clk_sync   <= {clk_sync[0], PS2CLK};
            dat_sync   <= {dat_sync[0], PS2DATA};
            clk_filt_d <= clk_filt;
            if (clk_sync[1] == clk_filt) begin
                flt_cnt <= '0;
            end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
                clk_filt <= clk_sync[1];
                flt_cnt  <= '0;
            end else begin
                flt_cnt <= flt_cnt + FW'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        err       = 1'b0;
        is_e0     = 1'b0;
        is_f0     = 1'b0;
        ev_vld    = 1'b0;
        frame_ok  = (^shreg[8:0]) & shreg[9];
        case (state)
            IDLE: if (strobe && !dat_s) state_nxt = RECV;
            RECV: begin
                if (strobe) begin
                    if (bit_cnt == 4'd10) state_nxt = CHECK;
                end else if (wd_cnt == WDW'(TIMEOUT_CYCLES - 1)) begin
                    state_nxt = IDLE;
                    err       = 1'b1;
                end
            end
            CHECK: begin
                state_nxt = IDLE;
                if (!frame_ok)              err    = 1'b1;
                else if (rx_byte == 8'hE0)  is_e0  = 1'b1;
                else if (rx_byte == 8'hF0)  is_f0  = 1'b1;
                else                        ev_vld = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign ev_dat   = '{ext: ext_pend, brk: brk_pend, code: rx_byte};
    assign push_vld = ev_vld && ((MODE == 0) || (MODE == 1 && !brk_pend) ||
                                 (MODE == 2 && brk_pend));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            wd_cnt    <= '0;
            ext_pend  <= 1'b0;
            brk_pend  <= 1'b0;
            LAST_KEY  <= '0;
            FRAME_ERR <= 1'b0;
            OVERFLOW  <= 1'b0;
        end else begin
            state     <= state_nxt;
            FRAME_ERR <= err;
            if (state == IDLE) bit_cnt <= 4'd1;
            if (state == RECV && strobe) begin
                shreg   <= {dat_s, shreg[9:1]};
                bit_cnt <= bit_cnt + 4'd1;
            end
            wd_cnt <= (state != RECV || strobe) ? '0 : wd_cnt + WDW'(1);
            if (err || ev_vld) begin
                ext_pend <= 1'b0;
                brk_pend <= 1'b0;
            end else begin
                if (is_e0) ext_pend <= 1'b1;
                if (is_f0) brk_pend <= 1'b1;
            end
            if (ev_vld && brk_pend) LAST_KEY <= rx_byte;
            // A drop in the same cycle as a clear leaves the flag set.
            if (push_vld && !push_rdy) OVERFLOW <= 1'b1;
            else if (CLR_OVF)          OVERFLOW <= 1'b0;
        end
    end

    sync_fifo #(.W($bits(ps2_ev_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
        .core_clk (CLK),
        .arst_n   (RST_N),
        .push_vld (push_vld),
        .push_dat (ev_dat),
        .push_rdy (push_rdy),
        .pop_vld  (RD_VALID),
        .pop_rdy  (RD_READY),
        .pop_dat  (head)
    );

    assign RD_CODE  = head.code;
    assign RD_BREAK = head.brk;
    assign RD_EXT   = head.ext;
endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Bench for ps2_scan_decoder: directed scenarios plus a randomized key stream
// checked against a queue-based model of the prefix/event rules.
`timescale 1ns/1ps
module tb_ps2_scan_decoder;
    localparam int FL = 8, TO = 2000, DEPTH = 8, HALF = 20;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ev_t;

    logic       CLK = 0, RST_N = 0, PS2CLK = 1, PS2DATA = 1, RD_READY = 0, CLR_OVF = 0;
    logic       RD_VALID, RD_BREAK, RD_EXT, FRAME_ERR, OVERFLOW;
    logic [7:0] RD_CODE, LAST_KEY;
    logic       m1_ready = 1'b1;
    logic       m1_valid, m1_break, m1_ext, m1_err, m1_ovf;
    logic [7:0] m1_code, m1_last;

    int  n_checks = 0, n_fail = 0, err_seen = 0;
    ev_t obs[$], obs1[$];

    ps2_scan_decoder #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO), .FIFO_DEPTH(DEPTH), .MODE(0)) dut (
        .CLK(CLK), .RST_N(RST_N), .PS2CLK(PS2CLK), .PS2DATA(PS2DATA), .RD_READY(RD_READY),
        .RD_VALID(RD_VALID), .RD_CODE(RD_CODE), .RD_BREAK(RD_BREAK), .RD_EXT(RD_EXT),
        .LAST_KEY(LAST_KEY), .FRAME_ERR(FRAME_ERR), .OVERFLOW(OVERFLOW), .CLR_OVF(CLR_OVF));

    ps2_scan_decoder #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO), .FIFO_DEPTH(DEPTH), .MODE(1)) dut_m1 (
        .CLK(CLK), .RST_N(RST_N), .PS2CLK(PS2CLK), .PS2DATA(PS2DATA), .RD_READY(m1_ready),
        .RD_VALID(m1_valid), .RD_CODE(m1_code), .RD_BREAK(m1_break), .RD_EXT(m1_ext),
        .LAST_KEY(m1_last), .FRAME_ERR(m1_err), .OVERFLOW(m1_ovf), .CLR_OVF(CLR_OVF));

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (RST_N && RD_VALID && RD_READY) obs.push_back({RD_EXT, RD_BREAK, RD_CODE});
        if (RST_N && m1_valid && m1_ready) obs1.push_back({m1_ext, m1_break, m1_code});
        if (RST_N && FRAME_ERR) err_seen++;
    end

    initial begin
        #900_000;
        $display("FAIL global_timeout simulation did not finish, checks=%0d", n_checks);
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge CLK); #1; end
    endtask

    function automatic logic [10:0] frame_bits(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        return {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    endfunction

    // Leaves PS2CLK low just after the final falling edge.
    task automatic drive_frame(input logic [10:0] f, input int nbits, input bit glitch);
        for (int i = 0; i < nbits; i++) begin
            PS2DATA = f[i];
            if (glitch && i == 5) begin
                tick(4); PS2CLK = 0; tick(FL - 1); PS2CLK = 1; tick(HALF - 4 - (FL - 1));
            end else begin
                tick(HALF);
            end
            PS2CLK = 0;
            if (i < nbits - 1) begin tick(HALF); PS2CLK = 1; end
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par = 1'b0,
                              input bit bad_stop = 1'b0, input bit glitch = 1'b0);
        drive_frame(frame_bits(b, bad_par, bad_stop), 11, glitch);
        tick(HALF); PS2CLK = 1; PS2DATA = 1; tick(HALF);
    endtask

    task automatic test_reset();
        RST_N = 0; tick(3);
        n_checks++; if ({RD_VALID, RD_CODE, RD_BREAK, RD_EXT} !== 11'd0) begin n_fail++;
            $display("FAIL reset_rd got %b want 0", {RD_VALID, RD_CODE, RD_BREAK, RD_EXT}); end
        n_checks++; if ({LAST_KEY, FRAME_ERR, OVERFLOW} !== 10'd0) begin n_fail++;
            $display("FAIL reset_misc got %h want 0", {LAST_KEY, FRAME_ERR, OVERFLOW}); end
        RST_N = 1; tick(5);
        n_checks++; if (RD_VALID !== 1'b0 || m1_valid !== 1'b0) begin n_fail++;
            $display("FAIL reset_valid got %b%b want 00", RD_VALID, m1_valid); end
    endtask

    task automatic test_reset_midframe();
        int e0;
        RD_READY = 1; obs.delete(); e0 = err_seen;
        drive_frame(frame_bits(8'h5A, 0, 0), 6, 0);
        RST_N = 0; tick(2); PS2CLK = 1; PS2DATA = 1; tick(2); RST_N = 1; tick(HALF);
        send_frame(8'h1C); tick(4);
        n_checks++; if (obs.size() !== 1 || (obs.size() > 0 && obs[0] !== ev_t'({2'b00, 8'h1C}))) begin n_fail++;
            $display("FAIL midreset_event got n=%0d want one 1C", obs.size()); end
        n_checks++; if (err_seen !== e0) begin n_fail++;
            $display("FAIL midreset_err got %0d want %0d", err_seen, e0); end
    endtask

    task automatic test_single();
        int lat = 0;
        RD_READY = 1; obs.delete();
        drive_frame(frame_bits(8'h1C, 0, 0), 11, 0);
        while (!RD_VALID && lat < 50) begin tick(1); lat++; end
        n_checks++; if (lat < FL + 3 || lat > FL + 6) begin n_fail++;
            $display("FAIL single_latency got %0d want %0d..%0d", lat, FL + 3, FL + 6); end
        n_checks++; if ({RD_EXT, RD_BREAK, RD_CODE} !== {2'b00, 8'h1C}) begin n_fail++;
            $display("FAIL single_event got %h want 01c", {RD_EXT, RD_BREAK, RD_CODE}); end
        tick(1);
        n_checks++; if (RD_VALID !== 1'b0) begin n_fail++;
            $display("FAIL single_width got %b want 0", RD_VALID); end
        PS2CLK = 1; PS2DATA = 1; tick(HALF);
        n_checks++; if (LAST_KEY !== 8'h00) begin n_fail++;
            $display("FAIL single_lastkey got %h want 00", LAST_KEY); end
    endtask

    task automatic test_break();
        RD_READY = 1; obs.delete();
        send_frame(8'hF0); send_frame(8'h1C);
        n_checks++; if (LAST_KEY !== 8'h1C) begin n_fail++;
            $display("FAIL break_lastkey1 got %h want 1c", LAST_KEY); end
        send_frame(8'hE0); send_frame(8'hF0); send_frame(8'h75);
        n_checks++; if (obs.size() !== 2) begin n_fail++;
            $display("FAIL break_count got %0d want 2", obs.size()); end
        else begin
            n_checks++; if (obs[0] !== ev_t'({2'b01, 8'h1C})) begin n_fail++;
                $display("FAIL break_ev0 got %h want 11c", obs[0]); end
            n_checks++; if (obs[1] !== ev_t'({2'b11, 8'h75})) begin n_fail++;
                $display("FAIL break_ev1 got %h want 375", obs[1]); end
        end
        n_checks++; if (LAST_KEY !== 8'h75) begin n_fail++;
            $display("FAIL break_lastkey2 got %h want 75", LAST_KEY); end
    endtask

    task automatic test_errors();
        int e0;
        RD_READY = 1; obs.delete(); e0 = err_seen;
        send_frame(8'h1C, 1'b1);
        n_checks++; if (err_seen !== e0 + 1 || obs.size() !== 0) begin n_fail++;
            $display("FAIL parity_err got err=%0d ev=%0d want err=%0d ev=0", err_seen, obs.size(), e0 + 1); end
        send_frame(8'h1B);
        n_checks++; if (obs.size() !== 1 || (obs.size() > 0 && obs[0] !== ev_t'({2'b00, 8'h1B}))) begin n_fail++;
            $display("FAIL after_err_event got n=%0d want one 1B", obs.size()); end
        send_frame(8'h2A, 1'b0, 1'b1);
        n_checks++; if (err_seen !== e0 + 2 || obs.size() !== 1) begin n_fail++;
            $display("FAIL stop_err got err=%0d ev=%0d want err=%0d ev=1", err_seen, obs.size(), e0 + 2); end
        obs.delete();
        send_frame(8'hF0); send_frame(8'h33, 1'b1); send_frame(8'h1C);
        n_checks++; if (obs.size() !== 1 || (obs.size() > 0 && obs[0] !== ev_t'({2'b00, 8'h1C}))) begin n_fail++;
            $display("FAIL err_clears_prefix got n=%0d want one make 1C", obs.size()); end
    endtask

    task automatic test_timeout();
        int e0;
        RD_READY = 1; obs.delete();
        send_frame(8'hE0);
        e0 = err_seen;
        drive_frame(frame_bits(8'h5A, 0, 0), 5, 0);
        tick(HALF); PS2CLK = 1; PS2DATA = 1;
        tick(TO / 2);
        n_checks++; if (err_seen !== e0) begin n_fail++;
            $display("FAIL timeout_early got %0d want %0d", err_seen, e0); end
        tick(TO / 2 + FL + 20);
        n_checks++; if (err_seen !== e0 + 1) begin n_fail++;
            $display("FAIL timeout_err got %0d want %0d", err_seen, e0 + 1); end
        send_frame(8'h23);
        n_checks++; if (obs.size() !== 1 || (obs.size() > 0 && obs[0] !== ev_t'({2'b00, 8'h23}))) begin n_fail++;
            $display("FAIL timeout_recover got n=%0d want one 23", obs.size()); end
    endtask

    task automatic test_overflow();
        RD_READY = 0; obs.delete();
        for (int c = 1; c <= DEPTH + 1; c++) send_frame(8'(c));
        n_checks++; if (OVERFLOW !== 1'b1 || RD_VALID !== 1'b1 || RD_CODE !== 8'h01) begin n_fail++;
            $display("FAIL ovf_full got ovf=%b v=%b code=%h want 1 1 01", OVERFLOW, RD_VALID, RD_CODE); end
        RD_READY = 1; tick(DEPTH + 2); RD_READY = 0;
        n_checks++; if (obs.size() !== DEPTH || RD_VALID !== 1'b0) begin n_fail++;
            $display("FAIL ovf_drain got n=%0d v=%b want %0d 0", obs.size(), RD_VALID, DEPTH); end
        for (int i = 0; i < obs.size(); i++) begin
            n_checks++; if (obs[i] !== ev_t'({2'b00, 8'(i + 1)})) begin n_fail++;
                $display("FAIL ovf_order[%0d] got %h want %h", i, obs[i], i + 1); end
        end
        n_checks++; if (OVERFLOW !== 1'b1) begin n_fail++;
            $display("FAIL ovf_sticky got %b want 1", OVERFLOW); end
        CLR_OVF = 1; tick(1); CLR_OVF = 0;
        n_checks++; if (OVERFLOW !== 1'b0) begin n_fail++;
            $display("FAIL ovf_clear got %b want 0", OVERFLOW); end

        obs.delete();
        for (int c = 1; c <= DEPTH; c++) send_frame(8'(c));
        drive_frame(frame_bits(8'(DEPTH + 1), 0, 0), 11, 0);
        tick(FL + 3); RD_READY = 1; tick(1); RD_READY = 0;
        tick(HALF); PS2CLK = 1; PS2DATA = 1; tick(HALF);
        n_checks++; if (OVERFLOW !== 1'b0) begin n_fail++;
            $display("FAIL ovf_push_pop got %b want 0", OVERFLOW); end
        RD_READY = 1; tick(DEPTH + 2); RD_READY = 0;
        n_checks++; if (obs.size() !== DEPTH + 1 || (obs.size() > DEPTH && obs[DEPTH] !== ev_t'({2'b00, 8'(DEPTH + 1)}))) begin n_fail++;
            $display("FAIL ovf_push_pop_data got n=%0d want %0d ending %h", obs.size(), DEPTH + 1, DEPTH + 1); end

        for (int c = 1; c <= DEPTH; c++) send_frame(8'(c));
        drive_frame(frame_bits(8'h0A, 0, 0), 11, 0);
        tick(FL + 3); CLR_OVF = 1; tick(1); CLR_OVF = 0;
        n_checks++; if (OVERFLOW !== 1'b1) begin n_fail++;
            $display("FAIL ovf_set_wins got %b want 1", OVERFLOW); end
        tick(HALF); PS2CLK = 1; PS2DATA = 1; tick(HALF);
        RD_READY = 1; tick(DEPTH + 2);
        CLR_OVF = 1; tick(1); CLR_OVF = 0;
    endtask

    task automatic test_glitch_mode();
        int e0;
        RD_READY = 1; obs.delete(); obs1.delete(); e0 = err_seen;
        send_frame(8'h4B, 1'b0, 1'b0, 1'b1);
        n_checks++; if (obs.size() !== 1 || err_seen !== e0 || (obs.size() > 0 && obs[0] !== ev_t'({2'b00, 8'h4B}))) begin n_fail++;
            $display("FAIL glitch_event got n=%0d err=%0d want one 4B, err=%0d", obs.size(), err_seen, e0); end
        obs1.delete();
        send_frame(8'hF0); send_frame(8'h1C);
        n_checks++; if (obs1.size() !== 0 || m1_last !== 8'h1C) begin n_fail++;
            $display("FAIL mode1_break got n=%0d last=%h want 0 1c", obs1.size(), m1_last); end
        send_frame(8'h1C);
        n_checks++; if (obs1.size() !== 1 || (obs1.size() > 0 && obs1[0] !== ev_t'({2'b00, 8'h1C}))) begin n_fail++;
            $display("FAIL mode1_make got n=%0d want one make 1C", obs1.size()); end
    endtask

    task automatic test_random();
        ev_t        exp[$];
        bit         ext = 0, brk = 0, done = 0;
        int         errs = 0, e0, r;
        logic [7:0] lk = 0, b;
        obs.delete(); e0 = err_seen;
        fork
            begin
                for (int i = 0; i < 30; i++) begin
                    r = $urandom_range(0, 7);
                    if (i == 28) r = 1;
                    if (i == 29) r = 5;
                    case (r)
                        0: begin send_frame(8'hE0); ext = 1; end
                        1: begin send_frame(8'hF0); brk = 1; end
                        2: begin b = 8'($urandom); send_frame(b, 1'b1); errs++; ext = 0; brk = 0; end
                        default: begin
                            b = 8'($urandom_range(1, 8'hDF));
                            send_frame(b);
                            exp.push_back({ext, brk, b});
                            if (brk) lk = b;
                            ext = 0; brk = 0;
                        end
                    endcase
                end
                done = 1;
            end
            begin
                while (!done) begin RD_READY = 1'($urandom); tick(1); end
            end
        join
        RD_READY = 1; tick(20);
        n_checks++; if (obs.size() !== exp.size()) begin n_fail++;
            $display("FAIL rand_count got %0d want %0d", obs.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < obs.size(); i++) begin
            n_checks++; if (obs[i] !== exp[i]) begin n_fail++;
                $display("FAIL rand_ev[%0d] got %h want %h", i, obs[i], exp[i]); end
        end
        n_checks++; if (err_seen - e0 !== errs) begin n_fail++;
            $display("FAIL rand_errs got %0d want %0d", err_seen - e0, errs); end
        n_checks++; if (LAST_KEY !== lk) begin n_fail++;
            $display("FAIL rand_lastkey got %h want %h", LAST_KEY, lk); end
    endtask

    initial begin
        test_reset();
        test_reset_midframe();
        test_single();
        test_break();
        test_errors();
        test_timeout();
        test_overflow();
        test_glitch_mode();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
